// File: rtl/ysyx_22050019_pipe_stage.sv
// Two-entry skid-buffered pipeline register with valid/ready handshake, flush and bubble zeroing.
// Difftest sideband flops exist only when YSYX_22050019_PIPE_DIFF_EN is defined; otherwise out_diff_o is 0.
module ysyx_22050019_pipe_stage #(
  parameter int DATA_W = 256,
  parameter int DIFF_W = 352
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [DIFF_W-1:0] in_diff_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [DIFF_W-1:0] out_diff_o,
  output logic [1:0]        occ_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] main_dat_q, skid_dat_q;
  logic accept, drain;
  logic ld_main_in, ld_main_skid, clr_main, ld_skid, clr_skid;

  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign occ_o       = state_q;
  assign out_data_o  = main_dat_q;

  // Register load/clear strobes shared by payload and sideband so both obey one set of rules.
  always_comb begin
    accept       = in_valid_i & in_ready_o;
    drain        = out_valid_o & out_ready_i;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    clr_main     = flush_i;
    ld_skid      = 1'b0;
    clr_skid     = flush_i;
    if (!flush_i) begin
      case (state_q)
        EMPTY: ld_main_in = accept;
        BUSY: begin
          ld_main_in = accept & drain;
          ld_skid    = accept & ~drain;
          clr_main   = ~accept & drain;
        end
        FULL: begin
          ld_main_skid = drain;
          clr_skid     = drain;
        end
        default: clr_main = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_q <= BUSY;
        BUSY: begin
          if (accept && !drain)      state_q <= FULL;
          else if (!accept && drain) state_q <= EMPTY;
        end
        FULL:    if (drain) state_q <= BUSY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_dat_q <= '0;
      skid_dat_q <= '0;
    end else begin
      if (clr_main)          main_dat_q <= '0;
      else if (ld_main_in)   main_dat_q <= in_data_i;
      else if (ld_main_skid) main_dat_q <= skid_dat_q;
      if (clr_skid)          skid_dat_q <= '0;
      else if (ld_skid)      skid_dat_q <= in_data_i;
    end
  end

`ifdef YSYX_22050019_PIPE_DIFF_EN
  logic [DIFF_W-1:0] main_diff_q, skid_diff_q;

  assign out_diff_o = main_diff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_diff_q <= '0;
      skid_diff_q <= '0;
    end else begin
      if (clr_main)          main_diff_q <= '0;
      else if (ld_main_in)   main_diff_q <= in_diff_i;
      else if (ld_main_skid) main_diff_q <= skid_diff_q;
      if (clr_skid)          skid_diff_q <= '0;
      else if (ld_skid)      skid_diff_q <= in_diff_i;
    end
  end
`else
  logic unused_diff;

  assign out_diff_o  = '0;
  assign unused_diff = ^in_diff_i;
`endif

endmodule

// File: tb/tb_ysyx_22050019_pipe_stage.sv
// Randomized scoreboard bench: a queue of in-flight beats models the stage; a negedge monitor checks outputs.
module tb_ysyx_22050019_pipe_stage;
  localparam int DATA_W = 256;
  localparam int DIFF_W = 352;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [DIFF_W-1:0] f;
  } beat_t;

  logic              clk, rst_n, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [DATA_W-1:0] in_data_i, out_data_o;
  logic [DIFF_W-1:0] in_diff_i, out_diff_o;
  logic [1:0]        occ_o;

  ysyx_22050019_pipe_stage #(.DATA_W(DATA_W), .DIFF_W(DIFF_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_diff_i(in_diff_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_diff_o(out_diff_o), .occ_o(occ_o)
  );

  int    checks = 0;
  int    errors = 0;
  int    delivered = 0;
  bit    mon_en = 0;
  bit    acc_pend = 0;
  beat_t pend_beat;
  beat_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i += 32) r[i+:32] = $urandom;
    return r;
  endfunction

  function automatic logic [DIFF_W-1:0] rnd_diff();
    logic [DIFF_W-1:0] r;
    for (int i = 0; i < DIFF_W; i += 32) r[i+:32] = $urandom;
    return r;
  endfunction

  // Monitor: status against the model's occupancy, payload against the oldest in-flight beat.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [DATA_W-1:0] ed;
      logic [DIFF_W-1:0] ef;
      int n;
      n = exp_q.size();
      ed = '0;
      ef = '0;
      if (n > 0) begin
        ed = exp_q[0].d;
`ifdef YSYX_22050019_PIPE_DIFF_EN
        ef = exp_q[0].f;
`endif
      end
      chk("occ", 512'(occ_o), 512'(n));
      chk("in_ready", 512'(in_ready_o), 512'(n < 2));
      chk("out_valid", 512'(out_valid_o), 512'(n > 0));
      chk("out_data", 512'(out_data_o), 512'(ed));
      chk("out_diff", 512'(out_diff_o), 512'(ef));
      if (n > 0 && out_ready_i) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (flush_i) exp_q.delete();
      else if (acc_pend) exp_q.push_back(pend_beat);
    end
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_data_i = '0; in_diff_i = '0;
    #3;
    chk("rst_occ", 512'(occ_o), 512'(0));
    chk("rst_in_ready", 512'(in_ready_o), 512'(1));
    chk("rst_out_valid", 512'(out_valid_o), 512'(0));
    chk("rst_out_data", 512'(out_data_o), 512'(0));
    #9;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int c = 0; c < 1503; c++) begin
      @(posedge clk);
      #1;
      if (c < 200) begin
        // streaming with small sequential payloads, then a pc-tagged sideband
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        flush_i     = 1'b0;
        in_data_i   = DATA_W'(c + 1);
        in_diff_i   = DIFF_W'(64'h8000_0000 + 64'(c));
      end else if (c < 1500) begin
        in_valid_i  = ($urandom_range(0, 3) != 0);
        out_ready_i = (c < 900) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        flush_i     = ($urandom_range(0, 15) == 0);
        in_data_i   = rnd_data();
        in_diff_i   = rnd_diff();
      end else begin
        in_valid_i  = 1'b1;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        in_data_i   = rnd_data();
        in_diff_i   = rnd_diff();
      end
      acc_pend    = in_valid_i && (exp_q.size() < 2) && !flush_i;
      pend_beat.d = in_data_i;
      pend_beat.f = in_diff_i;
    end

    // Asynchronous reset mid-cycle while full.
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    chk("pre_rst_occ", 512'(occ_o), 512'(2));
    rst_n = 1'b0;
    #1;
    chk("arst_occ", 512'(occ_o), 512'(0));
    chk("arst_in_ready", 512'(in_ready_o), 512'(1));
    chk("arst_out_valid", 512'(out_valid_o), 512'(0));
    chk("arst_out_data", 512'(out_data_o), 512'(0));
    chk("arst_out_diff", 512'(out_diff_o), 512'(0));
    in_valid_i = 1'b0;
    #20;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_occ", 512'(occ_o), 512'(0));
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL throughput: delivered %0d beats, required at least 100", delivered);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22050019_pipe_stage.md
# ysyx_22050019_pipe_stage

Parametrised, flow-controlled pipeline stage register that replaces the fixed-field, always-advancing inter-stage registers between ID/EX, EX/MEM and MEM/WB. It carries an opaque payload of configurable width through a two-entry skid buffer with a valid/ready handshake, synchronous flush and bubble zeroing. An optional difftest sideband travels in lock-step with the payload. Every core pipeline boundary instantiates one copy, with a per-boundary DATA_W.

## Interface
Parameters:
- DATA_W, 256, payload width in bits: packed control, operands, write-back info.
- DIFF_W, 352, difftest sideband width: pc 64 + inst 32 + 4 CSR snapshots 4×64.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush_i  input  1  synchronous kill of all held and incoming beats.
- in_valid_i  input  1  upstream beat valid.
- in_ready_o  output  1  stage can accept a beat this cycle.
- in_data_i  input  DATA_W  upstream payload.
- in_diff_i  input  DIFF_W  upstream difftest sideband.
- out_valid_o  output  1  downstream beat valid.
- out_ready_i  input  1  downstream accepts this cycle.
- out_data_o  output  DATA_W  payload to downstream.
- out_diff_o  output  DIFF_W  sideband to downstream.
- occ_o  output  2  number of held beats, 0..2.

## Operation
- Storage: main register (drives out_*) and skid register, each with a valid bit. Skid is never valid while main is invalid.
- accept = in_valid_i & in_ready_o; drain = out_valid_o & out_ready_i.
- States are encoded by occupancy:
  - EMPTY (0)
  - BUSY (1, main only)
  - FULL (2, main and skid)
- EMPTY transitions:
  - accept: BUSY, main ← input.
  - Otherwise: stay.
- BUSY transitions:
  - accept & drain: BUSY, main ← input.
  - accept & !drain: FULL, skid ← input.
  - !accept & drain: EMPTY, main cleared to 0.
  - Neither: hold.
- FULL transitions:
  - drain: BUSY, main ← skid, skid cleared to 0.
  - Otherwise: hold.
- in_ready_o = (state != FULL). It is decoded from registers only, with no combinational path from out_ready_i or in_valid_i.
- out_valid_o is main valid. occ_o is the state encoding.
- Bubble rule: whenever a register's valid bit is 0, its data and diff contents are 0. So out_data_o and out_diff_o read 0 whenever out_valid_o = 0.
- flush_i = 1:
  - Next state is EMPTY; both registers are cleared.
  - A beat accepted in the same cycle is discarded.
  - A drain in the same cycle still completes downstream, because downstream sampled it.
  - flush_i overrides every other transition.
- Payload is opaque: no field decoding and no width conversion. Bits are transferred unchanged, LSB-aligned.

## Timing
- Reset (rst_n low, asynchronous): state EMPTY; out_valid_o 0; in_ready_o 1; out_data_o 0; out_diff_o 0; occ_o 0. The block stays in this state until the first rising clk edge after rst_n deasserts.
- Latency: a beat accepted into an EMPTY stage appears on out_* in the next cycle.
- Throughput: one beat per cycle while out_ready_i stays high; no bubble is inserted.
- Backpressure: when out_ready_i drops, at most one extra beat is absorbed (into the skid register). in_ready_o falls in the cycle after the skid fills.
- Ordering: beats leave strictly in acceptance order.
- Reset during operation: all held beats are lost immediately and the outputs take their reset values asynchronously.

## Configuration
- YSYX_22050019_PIPE_DIFF_EN defined:
  - in_diff_i is registered alongside the payload through main and skid, following identical valid, bubble and flush rules.
- Not defined:
  - No diff flops are built.
  - out_diff_o is tied to constant 0.
  - in_diff_i is ignored.
  - Ports remain so instantiations are unchanged.

## Test plan
- Reset: drive rst_n low mid-cycle with occ 2 → outputs go immediately to out_valid_o 0, in_ready_o 1, occ_o 0, out_data_o 0.
- Streaming: out_ready_i held 1, beats 0x1,0x2,0x3 on consecutive cycles → out_data_o shows 0x1,0x2,0x3 on the three following cycles; in_ready_o stays 1; occ_o stays 1.
- Backpressure: with out_ready_i 0, send 0xA then 0xB → occ_o 2, in_ready_o 0, out_data_o 0xA. Raise out_ready_i for 2 cycles → 0xA then 0xB delivered, occ_o 0, out_data_o 0.
- Flush: occ 2 holding 0xC,0xD; assert flush_i with in_valid_i 1, data 0xE → next cycle occ_o 0, out_valid_o 0, out_data_o 0, and 0xE is never emitted.
- Diff sideband with macro defined: in_diff_i pc 0x80000000 with payload 0x5 → out_diff_o pc field 0x80000000 in the same cycle as 0x5. Without the macro, out_diff_o is 0 throughout.
